// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game FSM and its display back-end.
package whack_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'b000,
        ST_GAMEPLAY = 3'b001,
        ST_END      = 3'b010
    } game_state_e;

    // Non-decimal glyph codes understood by seg7_encode
    localparam logic [DIGIT_W-1:0] GLYPH_H     = 4'hA;
    localparam logic [DIGIT_W-1:0] GLYPH_E     = 4'hE;
    localparam logic [DIGIT_W-1:0] GLYPH_BLANK = 4'hF;

    typedef struct packed {
        logic               blank;
        logic [DIGIT_W-1:0] code;
    } glyph_t;

    function automatic glyph_t const_glyph(input logic [DIGIT_W-1:0] c);
        return '{blank: (c == GLYPH_BLANK), code: c};
    endfunction

    // Tens of a 0..15 value; a zero tens digit is suppressed
    function automatic glyph_t tens_glyph(input logic [DIGIT_W-1:0] v);
        return '{blank: (v <= 4'd9), code: 4'd1};
    endfunction

    function automatic glyph_t units_glyph(input logic [DIGIT_W-1:0] v);
        return '{blank: 1'b0, code: (v > 4'd9) ? v - 4'd10 : v};
    endfunction

    // Common d3..d0 layout: lead glyph, blank, tens, units
    function automatic glyph_t digit_glyph(input logic [1:0] idx, input glyph_t lead,
                                           input logic [DIGIT_W-1:0] v);
        glyph_t g;
        case (idx)
            2'd3:    g = lead;
            2'd2:    g = const_glyph(GLYPH_BLANK);
            2'd1:    g = tens_glyph(v);
            default: g = units_glyph(v);
        endcase
        return g;
    endfunction

endpackage

// File: rtl/game_display_seg7_encode.sv
// Digit/glyph code to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_encode
    import whack_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = 7'h7F;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = 7'h40;
                4'd1:    seg_c = 7'h79;
                4'd2:    seg_c = 7'h24;
                4'd3:    seg_c = 7'h30;
                4'd4:    seg_c = 7'h19;
                4'd5:    seg_c = 7'h12;
                4'd6:    seg_c = 7'h02;
                4'd7:    seg_c = 7'h78;
                4'd8:    seg_c = 7'h00;
                4'd9:    seg_c = 7'h10;
                GLYPH_H: seg_c = 7'h09;
                GLYPH_E: seg_c = 7'h06;
                default: seg_c = 7'h7F;
            endcase
        end
    end

endmodule

// File: rtl/game_display.sv
// Whack-a-mole presentation back-end: 4-digit multiplexed seven-segment
// display, mole LED, final/high score capture and end-screen blink.
module game_display
    import whack_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_HALF  = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic [DIGIT_W-1:0] score,
    input  logic [DIGIT_W-1:0] lives,
    input  logic               mole,
    output logic [3:0]         an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp,
    output logic               mole_led,
    output logic [DIGIT_W-1:0] high_score
);

    localparam int unsigned REFRESH_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W   = $clog2(BLINK_HALF);

    logic [STATE_W-1:0]   prev_state;
    logic [DIGIT_W-1:0]   last_score;
    logic [DIGIT_W-1:0]   final_score;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic [1:0]           digit_idx;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_on;

    logic                 capture_c;
    logic                 disp_blank_c;
    logic                 dp_c;
    logic                 mole_c;
    logic [DIGIT_W-1:0]   lives_cap_c;
    glyph_t               glyph_c;
    logic [SEG_W-1:0]     seg_c;

    // last_score shadows the live score because the game clears it on game over
    assign capture_c = (state == ST_END) && (prev_state == ST_GAMEPLAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state  <= ST_IDLE;
            last_score  <= '0;
            final_score <= '0;
            high_score  <= '0;
        end else begin
            prev_state <= state;
            if (state == ST_GAMEPLAY) last_score <= score;
            if (capture_c) begin
                final_score <= last_score;
                if (last_score > high_score) high_score <= last_score;
            end
        end
    end

    // Digit scan runs freely, independent of game state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_W'(1);
        end
    end

    // Held in the on phase outside END_SCREEN so the end screen opens lit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != ST_END) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_comb begin
        glyph_c      = const_glyph(GLYPH_BLANK);
        disp_blank_c = 1'b1;
        dp_c         = 1'b1;
        mole_c       = 1'b0;
        lives_cap_c  = (lives > 4'd9) ? 4'd9 : lives;
        case (state)
            ST_IDLE: begin
                disp_blank_c = 1'b0;
                glyph_c      = digit_glyph(digit_idx, const_glyph(GLYPH_H), high_score);
            end
            ST_GAMEPLAY: begin
                disp_blank_c = 1'b0;
                glyph_c      = digit_glyph(digit_idx, units_glyph(lives_cap_c), score);
                dp_c         = !((digit_idx == 2'd3) && (lives == 4'd1));
                mole_c       = mole;
            end
            ST_END: begin
                disp_blank_c = ~blink_on;
                glyph_c      = digit_glyph(digit_idx, const_glyph(GLYPH_E), final_score);
                mole_c       = blink_on;
            end
            default: ;
        endcase
    end

    seg7_encode u_seg7 (
        .digit (glyph_c.code),
        .blank (glyph_c.blank),
        .seg_c (seg_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an       <= 4'hF;
            seg      <= 7'h7F;
            dp       <= 1'b1;
            mole_led <= 1'b0;
        end else begin
            an       <= disp_blank_c ? 4'hF : ~(4'b0001 << digit_idx);
            seg      <= disp_blank_c ? 7'h7F : seg_c;
            dp       <= dp_c;
            mole_led <= mole_c;
        end
    end

endmodule

// File: tb/tb_game_display.sv
// Self-checking bench for game_display: vector table, game-over sequences,
// randomized stimulus against a cycle-count based reference model.
module tb_game_display;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned BLINK_HALF  = 8;

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  sc;
        logic [3:0]  lv;
        logic        mo;
        logic [31:0] disp;
        logic        dp3;
        logic [3:0]  hs;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic [3:0] score;
    logic [3:0] lives;
    logic       mole;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       mole_led;
    logic [3:0] high_score;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: cycles since reset, length of current END run, scores
    int         m_n;
    int         m_end_run;
    logic [2:0] m_prev;
    logic [3:0] m_last;
    logic [3:0] m_final;
    logic [3:0] m_high;

    vec_t tbl [7];

    game_display #(.REFRESH_DIV(REFRESH_DIV), .BLINK_HALF(BLINK_HALF)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .score      (score),
        .lives      (lives),
        .mole       (mole),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .mole_led   (mole_led),
        .high_score (high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "0": return 7'h40;
            "1": return 7'h79;
            "2": return 7'h24;
            "3": return 7'h30;
            "4": return 7'h19;
            "5": return 7'h12;
            "6": return 7'h02;
            "7": return 7'h78;
            "8": return 7'h00;
            "9": return 7'h10;
            "H": return 7'h09;
            "E": return 7'h06;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic byte digit_char(input int v);
        return byte'(48 + v);
    endfunction

    function automatic byte disp_char(input int d, input byte lead, input logic [3:0] v);
        case (d)
            3:       return lead;
            2:       return " ";
            1:       return (v >= 4'd10) ? "1" : " ";
            default: return digit_char(int'(v) % 10);
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0; m_end_run = 0; m_prev = 3'd0;
        m_last = 4'd0; m_final = 4'd0; m_high = 4'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_an"},  32'(an),         32'hF);
        chk({tag, "_seg"}, 32'(seg),        32'h7F);
        chk({tag, "_dp"},  32'(dp),         32'd1);
        chk({tag, "_led"}, 32'(mole_led),   32'd0);
        chk({tag, "_hs"},  32'(high_score), 32'd0);
    endtask

    // One clock: predict outputs from current inputs, advance model, compare
    task automatic step();
        int         d;
        byte        ch;
        bit         blank;
        bit         on;
        logic       e_dp;
        logic       e_mole;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        d = int'((m_n / REFRESH_DIV) % 4);
        blank = 1'b0; on = 1'b1; e_dp = 1'b1; e_mole = 1'b0; ch = " ";
        case (state)
            3'd0: ch = disp_char(d, "H", m_high);
            3'd1: begin
                ch     = disp_char(d, digit_char((lives > 4'd9) ? 9 : int'(lives)), score);
                e_dp   = !(d == 3 && lives == 4'd1);
                e_mole = mole;
            end
            3'd2: begin
                on     = ((m_end_run / BLINK_HALF) % 2) == 0;
                blank  = !on;
                ch     = disp_char(d, "E", m_final);
                e_mole = on;
            end
            default: blank = 1'b1;
        endcase
        e_an = 4'hF;
        if (!blank) e_an[d] = 1'b0;
        e_seg = blank ? 7'h7F : seg_of(ch);

        if (state == 3'd2 && m_prev == 3'd1) begin
            m_final = m_last;
            if (m_last > m_high) m_high = m_last;
        end
        if (state == 3'd1) m_last = score;
        m_end_run = (state == 3'd2) ? m_end_run + 1 : 0;
        m_prev = state;
        m_n++;

        @(posedge clk);
        #1;
        chk("an",         32'(an),         32'(e_an));
        chk("seg",        32'(seg),        32'(e_seg));
        chk("dp",         32'(dp),         32'(e_dp));
        chk("mole_led",   32'(mole_led),   32'(e_mole));
        chk("high_score", 32'(high_score), 32'(m_high));
    endtask

    // Hold a vector, then check every slot of a full scan against its d3..d0 text
    task automatic run_vec(input vec_t v);
        int         d;
        logic [3:0] pat;
        state = v.st; score = v.sc; lives = v.lv; mole = v.mo;
        repeat (4) step();
        for (int k = 0; k < 16; k++) begin
            step();
            d = -1;
            for (int j = 0; j < 4; j++) begin
                pat = 4'hF;
                pat[j] = 1'b0;
                if (an == pat) d = j;
            end
            chk("tbl_onehot", 32'(d >= 0), 32'd1);
            if (d >= 0) begin
                chk("tbl_seg", 32'(seg), 32'(seg_of(v.disp[8*d +: 8])));
                chk("tbl_dp",  32'(dp),  32'((d == 3) ? v.dp3 : 1'b1));
            end
            chk("tbl_hs", 32'(high_score), 32'(v.hs));
        end
    endtask

    task automatic play_game(input logic [3:0] final_sc, input logic [3:0] exp_hs);
        state = 3'd0; score = 4'd0;
        repeat (3) step();
        state = 3'd1; lives = 4'd2;
        score = 4'($urandom_range(0, 15));
        repeat (5) step();
        score = final_sc;
        step();
        state = 3'd2; score = 4'd0;
        repeat (2) step();
        chk("hs_after_game", 32'(high_score), 32'(exp_hs));
        repeat (18) step();
    endtask

    initial begin
        tbl[0] = '{3'd0, 4'd0,  4'd0,  1'b0, "H  0", 1'b1, 4'd0};
        tbl[1] = '{3'd1, 4'd13, 4'd3,  1'b1, "3 13", 1'b1, 4'd0};
        tbl[2] = '{3'd1, 4'd13, 4'd1,  1'b0, "1 13", 1'b0, 4'd0};
        tbl[3] = '{3'd1, 4'd13, 4'd12, 1'b1, "9 13", 1'b1, 4'd0};
        tbl[4] = '{3'd1, 4'd5,  4'd0,  1'b0, "0  5", 1'b1, 4'd0};
        tbl[5] = '{3'd1, 4'd10, 4'd9,  1'b1, "9 10", 1'b1, 4'd0};
        tbl[6] = '{3'd0, 4'd0,  4'd0,  1'b0, "H 15", 1'b1, 4'd15};

        reset = 1'b1; state = 3'd0; score = 4'd0; lives = 4'd0; mole = 1'b0;
        model_reset();
        #3;
        check_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_an;
            step();
            exp_an = 4'hF;
            exp_an[i / 4] = 1'b0;
            chk("scan_order", 32'(an), 32'(exp_an));
        end

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // First game: score changes on the last GAMEPLAY cycle, cleared on entry to END
        state = 3'd1; lives = 4'd3; score = 4'd6;
        repeat (3) step();
        score = 4'd7;
        step();
        state = 3'd2; score = 4'd0;
        step();
        chk("hs_game1", 32'(high_score), 32'd7);
        chk("blink_led0", 32'(mole_led), 32'd1);
        for (int k = 1; k < 32; k++) begin
            step();
            chk("blink_led", 32'(mole_led), 32'(((k / 8) % 2) == 0));
            if (((k / 8) % 2) == 1) chk("blink_off_an", 32'(an), 32'hF);
        end

        play_game(4'd5,  4'd7);
        play_game(4'd7,  4'd7);
        play_game(4'd15, 4'd15);
        run_vec(tbl[6]);

        state = 3'b011; mole = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("inv_an",  32'(an),       32'hF);
            chk("inv_led", 32'(mole_led), 32'd0);
        end

        state = 3'd0; mole = 1'b0;
        repeat (4) step();
        state = 3'd2;
        repeat (20) step();
        chk("direct_end_hs", 32'(high_score), 32'd15);

        for (int s = 0; s < 120; s++) begin
            int r;
            int hold;
            r = int'($urandom_range(0, 9));
            if (r < 3)      state = 3'd0;
            else if (r < 7) state = 3'd1;
            else if (r < 9) state = 3'd2;
            else            state = 3'($urandom_range(3, 7));
            hold = int'($urandom_range(1, 24));
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 3) == 0) score = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) lives = 4'($urandom_range(0, 15));
                mole = 1'($urandom_range(0, 1));
                step();
            end
        end

        // Asynchronous reset in the middle of an end screen
        state = 3'd0;
        reset = 1'b1;
        #1;
        check_reset_vals("rst2");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        play_game(4'd9, 4'd9);
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_end");
        @(posedge clk); #1;
        check_reset_vals("held");
        reset = 1'b0;
        model_reset();
        step();
        chk("scan_restart", 32'(an), 32'hE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_display.md
# game_display

Presentation back-end for the whack-a-mole game. Consumes the game FSM's `state`, `score`, `lives` and `mole` outputs and drives the board's 4-digit multiplexed seven-segment display and the mole LED. Captures the final score at game over, maintains a session high score, and blinks the end screen.

## Interface
- `REFRESH_DIV`, 100_000: clk cycles each digit is lit; min 2.
- `BLINK_HALF`, 50_000_000: clk cycles per blink half-period (0.5 s at 100 MHz); min 2.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `state` in 3: game state; 000 IDLE, 001 GAMEPLAY, 010 END_SCREEN; others invalid.
- `score` in 4: live score, 0–15.
- `lives` in 4: remaining lives, 0–15.
- `mole` in 1: mole visible.
- `an` out 4: digit enables, active-low; `an[0]` is the rightmost digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `mole_led` out 1: mole LED, active-high.
- `high_score` out 4: best final score since reset.

## Operation
- Registers:
  - `prev_state`: `state` delayed by one cycle.
  - `last_score`: loads `score` every cycle `state`==GAMEPLAY.
  - `final_score`: loads `last_score` on the cycle `state`==END_SCREEN and `prev_state`==GAMEPLAY.
  - `high_score`: on that same cycle, loads `last_score` if `last_score` > `high_score` (strict, unsigned).
- Final score must come from `last_score`: the game clears `score` while in END_SCREEN.
- Digit content per state (d3..d0):
  - IDLE: `H`, blank, high_score tens, high_score units.
  - GAMEPLAY: lives units, blank, score tens, score units. Lives >9 shows 9. The dp of d3 is on when `lives`==1 (low-life warning).
  - END_SCREEN: `E`, blank, final_score tens, final_score units. All four digits are blanked during the blink-off phase.
  - Invalid code: all digits blank, dp off.
- Decimal split of 0–15: tens = (v>9), units = v−10 when v>9, else v.
- A tens digit of 0 is displayed blank (leading-zero suppression).
- mole_led:
  - GAMEPLAY: follows `mole`.
  - END_SCREEN: equals the blink phase.
  - Otherwise 0.
- Scan: `refresh_cnt` counts 0..REFRESH_DIV−1 and wraps. On wrap, `digit_idx` (2 bits) increments 0→1→2→3→0. Exactly one `an` bit is low, selected by `digit_idx`.
- Blink:
  - `blink_cnt` counts 0..BLINK_HALF−1; on wrap, `blink_on` toggles.
  - `blink_cnt` clears to 0 and `blink_on` sets to 1 on every cycle `state`!=END_SCREEN.
  - As a result, END_SCREEN always starts in the on phase.
- A state change mid-scan does not reset `refresh_cnt` or `digit_idx`.

## Timing
- Reset values:
  - `an`=1111, `seg`=1111111, `dp`=1, `mole_led`=0, `high_score`=0.
  - `final_score`=0, `last_score`=0, `prev_state`=IDLE.
  - `refresh_cnt`=0, `digit_idx`=0, `blink_cnt`=0, `blink_on`=1.
- All outputs are registered: input change to `an`/`seg`/`dp`/`mole_led` takes 1 clk.
- `high_score` updates 1 clk after the GAMEPLAY→END_SCREEN edge is seen on `state`. `final_score` appears on the display on the following cycle.
- GAMEPLAY→END_SCREEN with `score` changing on the last GAMEPLAY cycle: the value captured is the one present on that last GAMEPLAY cycle.
- Any direct IDLE→END_SCREEN entry (no preceding GAMEPLAY) leaves `final_score` and `high_score` unchanged.
- Reset asserted mid-operation clears everything, including `high_score`, asynchronously. Outputs go to their reset values in the same cycle.

## Structure
- Shared package `whack_pkg`:
  - State codes ST_IDLE, ST_GAMEPLAY, ST_END.
  - Glyph constants GLYPH_H, GLYPH_E, GLYPH_BLANK.
  - The game FSM and this block both use it.
- Sub-module `seg7_encode`: combinational. 4-bit digit plus blank flag in, 7-bit active-low pattern out. Instantiated once, after the digit mux.

## Test plan
Bench uses REFRESH_DIV=4, BLINK_HALF=8.
- Reset release, state=IDLE: `an` sequence 1110,1101,1011,0111 with 4 clk each. `seg` shows `H`, blank, blank, 0 (high score 0).
- GAMEPLAY, score=13, lives=3: d0=3, d1=1, d3=3, dp off. Then lives=1: d3 dp low on its slot. Then lives=12: d3 shows 9.
- GAMEPLAY score 7→ state=END_SCREEN with score forced to 0 the same cycle: display shows `E`, blank, blank, 7. `high_score`=7.
  - Toggles every 8 clk: blank on/off and `mole_led` alternating, starting on.
- Second game ending at 5: `high_score` stays 7 and display shows 5. Third game ending at 7: `high_score` stays 7. Fourth ending at 15: `high_score`=15 and IDLE shows `H`, blank, 1, 5.
- state=011: all `an` high through a full scan, `mole_led`=0. Then IDLE→END_SCREEN directly: `final_score` and `high_score` unchanged.
- Reset asserted mid-END_SCREEN with `high_score`=9: outputs at reset values in the same cycle, `high_score`=0, scan restarts at `an`=1110.
